pkt_capture_stage: RTL

// Store-and-forward stage upstream of the pipelined processor datapath. Captures one packet from
// the 64-bit data/ctrl stream into a local buffer, lets the processor read/modify it through a

---
 rtl/pkt_capture_stage_pkg.sv | 19 +
 rtl/pkt_capture_stage_if.sv | 37 +++
 rtl/pkt_buf_ram.sv | 32 +++
 rtl/pkt_capture_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pkt_capture_stage_pkg.sv
// Shared definitions for the packet capture stage: state encoding, buffer depth, EOP rule.
package pkt_capture_stage_pkg;

    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefCtrlWidth = DefDataWidth / 8;
    localparam int unsigned DefAddrWidth = 8;

    typedef enum logic [1:0] {StIdle, StRecv, StProc, StSend} state_e;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // A non-zero ctrl word closes the packet only once a payload (ctrl == 0) word has been seen.
    function automatic logic is_eop(input logic wr, input logic body_seen, input logic ctrl_nonzero);
        return wr & body_seen & ctrl_nonzero;
    endfunction

endpackage

// File: rtl/pkt_capture_stage_if.sv
// Stream, processor and statistics signals of the packet capture stage.
interface pkt_capture_stage_if #(
    parameter int unsigned DATA_WIDTH = pkt_capture_stage_pkg::DefDataWidth,
    parameter int unsigned CTRL_WIDTH = pkt_capture_stage_pkg::DefCtrlWidth,
    parameter int unsigned ADDR_WIDTH = pkt_capture_stage_pkg::DefAddrWidth
);
    logic [DATA_WIDTH-1:0]            in_data;
    logic [CTRL_WIDTH-1:0]            in_ctrl;
    logic                             in_wr;
    logic                             in_rdy;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic                             proc_valid;
    logic [ADDR_WIDTH:0]              proc_len;
    logic [ADDR_WIDTH-1:0]            proc_addr;
    logic [DATA_WIDTH+CTRL_WIDTH-1:0] proc_rdata;
    logic [DATA_WIDTH+CTRL_WIDTH-1:0] proc_wdata;
    logic                             proc_we;
    logic                             proc_done;
    logic [31:0]                      pkt_cnt;
    logic [31:0]                      drop_cnt;

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy, proc_addr, proc_wdata, proc_we, proc_done,
        input  in_rdy, out_data, out_ctrl, out_wr, proc_valid, proc_len, proc_rdata,
               pkt_cnt, drop_cnt
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy, proc_addr, proc_wdata, proc_we, proc_done,
        output in_rdy, out_data, out_ctrl, out_wr, proc_valid, proc_len, proc_rdata,
               pkt_cnt, drop_cnt
    );

endinterface

// File: rtl/pkt_buf_ram.sv
// True dual-port packet buffer, synchronous read on both ports, single clock.
module pkt_buf_ram #(
    parameter int unsigned WIDTH      = 72,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  a_we_i,
    input  logic                  a_re_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [WIDTH-1:0]      a_wdata_i,
    output logic [WIDTH-1:0]      a_rdata_o,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [WIDTH-1:0]      b_wdata_i,
    output logic [WIDTH-1:0]      b_rdata_o
);
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [WIDTH-1:0] a_rdata_q;
    logic [WIDTH-1:0] b_rdata_q;

    // Port A holds its last read while a_re_i is low so a stalled output can be refilled later.
    always_ff @(posedge clk_i) begin
        if (a_we_i) mem[a_addr_i] <= a_wdata_i;
        if (b_we_i) mem[b_addr_i] <= b_wdata_i;
        if (a_re_i) a_rdata_q <= mem[a_addr_i];
        b_rdata_q <= mem[b_addr_i];
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/pkt_capture_stage.sv
// Store-and-forward stage: capture one packet, hand it to the processor, replay it downstream.
module pkt_capture_stage
    import pkt_capture_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned CTRL_WIDTH = DefCtrlWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input logic                clk,
    input logic                reset,
    pkt_capture_stage_if.slave bus
);
    localparam int unsigned WordWidth = DATA_WIDTH + CTRL_WIDTH;
    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t Full = ptr_t'(depth_of(ADDR_WIDTH));

    state_e                state_q, state_d;
    ptr_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, proc_len_q, proc_len_d;
    logic                  body_q, body_d, ovf_q, ovf_d, rd_vld_q, rd_vld_d;
    logic                  out_wr_q, out_wr_d, proc_valid_q, proc_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic [31:0]           pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                  ram_a_we, ram_a_re, proc_we_gated, load_out, accept;
    logic [ADDR_WIDTH-1:0] ram_a_addr;
    logic [WordWidth-1:0]  ram_a_rdata;

    assign proc_we_gated = bus.proc_we & (state_q == StProc);
    assign ram_a_addr = (state_q == StSend) ? rd_ptr_q[ADDR_WIDTH-1:0] : wr_ptr_q[ADDR_WIDTH-1:0];

    pkt_buf_ram #(
        .WIDTH      (WordWidth),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buf (
        .clk_i     (clk),
        .a_we_i    (ram_a_we),
        .a_re_i    (ram_a_re),
        .a_addr_i  (ram_a_addr),
        .a_wdata_i ({bus.in_ctrl, bus.in_data}),
        .a_rdata_o (ram_a_rdata),
        .b_we_i    (proc_we_gated),
        .b_addr_i  (bus.proc_addr),
        .b_wdata_i (bus.proc_wdata),
        .b_rdata_o (bus.proc_rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        proc_len_d   = proc_len_q;
        body_d       = body_q;
        ovf_d        = ovf_q;
        rd_vld_d     = rd_vld_q;
        out_wr_d     = out_wr_q;
        out_data_d   = out_data_q;
        out_ctrl_d   = out_ctrl_q;
        proc_valid_d = proc_valid_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        ram_a_we     = 1'b0;
        ram_a_re     = 1'b0;
        load_out     = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_wr) begin
                    ram_a_we = 1'b1;
                    wr_ptr_d = ptr_t'(1);
                    body_d   = (bus.in_ctrl == '0);
                    state_d  = StRecv;
                end
            end
            StRecv: begin
                if (bus.in_wr) begin
                    if (wr_ptr_q == Full) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_a_we = 1'b1;
                        wr_ptr_d = wr_ptr_q + ptr_t'(1);
                    end
                    if (bus.in_ctrl == '0) body_d = 1'b1;
                    if (is_eop(bus.in_wr, body_q, bus.in_ctrl != '0)) begin
                        wr_ptr_d = '0;
                        body_d   = 1'b0;
                        ovf_d    = 1'b0;
                        if (ovf_q || wr_ptr_q == Full) begin
                            drop_cnt_d = drop_cnt_q + 32'd1;
                            state_d    = StIdle;
                        end else begin
                            proc_len_d   = wr_ptr_q + ptr_t'(1);
                            proc_valid_d = 1'b1;
                            state_d      = StProc;
                        end
                    end
                end
            end
            StProc: begin
                if (bus.proc_done) begin
                    proc_valid_d = 1'b0;
                    rd_ptr_d     = '0;
                    state_d      = StSend;
                end
            end
            StSend: begin
                load_out = rd_vld_q & (~out_wr_q | bus.out_rdy);
                accept   = out_wr_q & bus.out_rdy;
                // Prefetch whenever the RAM output stage is empty or is draining this cycle.
                if (rd_ptr_q != proc_len_q && (!rd_vld_q || load_out)) begin
                    ram_a_re = 1'b1;
                    rd_ptr_d = rd_ptr_q + ptr_t'(1);
                end
                if (ram_a_re) rd_vld_d = 1'b1;
                else if (load_out) rd_vld_d = 1'b0;
                if (load_out) begin
                    out_wr_d   = 1'b1;
                    out_data_d = ram_a_rdata[DATA_WIDTH-1:0];
                    out_ctrl_d = ram_a_rdata[DATA_WIDTH +: CTRL_WIDTH];
                end else if (accept) begin
                    out_wr_d = 1'b0;
                end
                // Last word leaves when nothing is left in flight behind it.
                if (accept && !rd_vld_q && rd_ptr_q == proc_len_q) begin
                    out_wr_d  = 1'b0;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            proc_len_q   <= '0;
            body_q       <= 1'b0;
            ovf_q        <= 1'b0;
            rd_vld_q     <= 1'b0;
            out_wr_q     <= 1'b0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            proc_valid_q <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            proc_len_q   <= proc_len_d;
            body_q       <= body_d;
            ovf_q        <= ovf_d;
            rd_vld_q     <= rd_vld_d;
            out_wr_q     <= out_wr_d;
            out_data_q   <= out_data_d;
            out_ctrl_q   <= out_ctrl_d;
            proc_valid_q <= proc_valid_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.in_rdy     = (state_q == StIdle) || (state_q == StRecv);
    assign bus.out_wr     = out_wr_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_ctrl   = out_ctrl_q;
    assign bus.proc_valid = proc_valid_q;
    assign bus.proc_len   = proc_len_q;
    assign bus.pkt_cnt    = pkt_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule
